// File: rtl/im_boot_loader.sv
// Framed byte-stream loader that fills the CPU instruction memory and holds
// the CPU in reset until a frame with a matching XOR checksum has been stored.
module im_boot_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic [31:0]           im_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'(1 << ADDR_WIDTH);

  state_t                state_q, state_d;
  logic [7:0]            len_hi_q, len_hi_d;
  logic [16:0]           rem_q, rem_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [23:0]           asm_q, asm_d;
  logic [7:0]            xor_q, xor_d;
  logic                  im_we_q, im_we_d;
  logic [ADDR_WIDTH-1:0] im_addr_q, im_addr_d;
  logic [31:0]           im_wdata_q, im_wdata_d;
  logic                  accept;
  logic [16:0]           len_full;

  assign rx_ready  = (state_q != S_DONE) && (state_q != S_ERROR);
  assign busy      = (state_q == S_LEN_LO) || (state_q == S_DATA) || (state_q == S_CHECK);
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERROR);
  assign cpu_reset = (state_q == S_DONE);
  assign im_we     = im_we_q;
  assign im_addr   = im_addr_q;
  assign im_wdata  = im_wdata_q;

  assign accept   = rx_valid && rx_ready;
  assign len_full = {1'b0, len_hi_q, rx_data};

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_LEN_HI;
      len_hi_q   <= '0;
      rem_q      <= '0;
      idx_q      <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      xor_q      <= '0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      xor_q      <= xor_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    rem_d      = rem_q;
    idx_d      = idx_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    xor_d      = xor_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;

    case (state_q)
      S_LEN_HI: begin
        xor_d      = '0;
        byte_cnt_d = '0;
        idx_d      = '0;
        if (accept) begin
          len_hi_d = rx_data;
          state_d  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          rem_d = len_full;
          if (len_full > MAX_WORDS)    state_d = S_ERROR;
          else if (len_full == 17'd0)  state_d = S_CHECK;
          else                         state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          xor_d      = xor_q ^ rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          asm_d      = {asm_q[15:0], rx_data};
          if (byte_cnt_q == 2'd3) begin
            im_we_d    = 1'b1;
            im_addr_d  = idx_q;
            im_wdata_d = {asm_q, rx_data};
            rem_d      = rem_q - 17'd1;
            // Last word: leave the index alone so it never wraps at full capacity.
            if (rem_q == 17'd1) state_d = S_CHECK;
            else                idx_d   = idx_q + ADDR_WIDTH'(1);
          end
        end
      end
      S_CHECK: begin
        if (accept) state_d = (rx_data == xor_q) ? S_DONE : S_ERROR;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_im_boot_loader.sv
// Directed bench for im_boot_loader: a default-size instance for framing and
// checksum cases, and a 16-word instance for the capacity boundary.
module tb_im_boot_loader;

  logic        clock;
  logic        reset;
  logic [7:0]  rx_data,  rx_data4;
  logic        rx_valid, rx_valid4;
  logic        rx_ready, rx_ready4;
  logic        im_we,    im_we4;
  logic [9:0]  im_addr;
  logic [3:0]  im_addr4;
  logic [31:0] im_wdata, im_wdata4;
  logic        cpu_reset, cpu_reset4;
  logic        busy, busy4, done, done4, error, error4;

  im_boot_loader #(.ADDR_WIDTH(10)) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
  );

  im_boot_loader #(.ADDR_WIDTH(4)) dut4 (
    .clock(clock), .reset(reset), .rx_data(rx_data4), .rx_valid(rx_valid4),
    .rx_ready(rx_ready4), .im_we(im_we4), .im_addr(im_addr4), .im_wdata(im_wdata4),
    .cpu_reset(cpu_reset4), .busy(busy4), .done(done4), .error(error4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  logic [9:0]  wa_log [$];
  logic [31:0] wd_log [$];
  int          wc_log [$];
  int          w4_n;
  logic [3:0]  w4_last_addr;
  logic [31:0] w4_last_data;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (im_we === 1'b1) begin
      wa_log.push_back(im_addr);
      wd_log.push_back(im_wdata);
      wc_log.push_back(cyc);
      $display("write  addr=%0d data=%h cycle=%0d", im_addr, im_wdata, cyc);
    end
    if (im_we4 === 1'b1) begin
      w4_n++;
      w4_last_addr = im_addr4;
      w4_last_data = im_wdata4;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wa_log.delete();
    wd_log.delete();
    wc_log.delete();
  endtask

  function automatic logic [31:0] log_data(input int i);
    return (i < wd_log.size()) ? wd_log[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] log_addr(input int i);
    return (i < wa_log.size()) ? 32'(wa_log[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic int log_gap();
    return (wc_log.size() >= 2) ? (wc_log[1] - wc_log[0]) : -1;
  endfunction

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clock); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send4(input logic [7:0] b);
    rx_data4  = b;
    rx_valid4 = 1'b1;
    @(posedge clock); #1;
    rx_valid4 = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  logic [7:0] good [11];
  logic [7:0] bad  [11];
  logic [7:0] one  [7];

  initial begin
    // XOR of the eight data bytes is 0x55.
    good = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h55};
    bad  = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h5E};
    one  = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    reset = 1'b0; rx_data = '0; rx_valid = 1'b0; rx_data4 = '0; rx_valid4 = 1'b0;
    w4_n = 0; w4_last_addr = '0; w4_last_data = '0;
    repeat (2) @(posedge clock);
    #1;

    check("rst rx_ready",  32'(rx_ready),  32'd1);
    check("rst im_we",     32'(im_we),     32'd0);
    check("rst im_addr",   32'(im_addr),   32'd0);
    check("rst im_wdata",  im_wdata,       32'd0);
    check("rst cpu_reset", 32'(cpu_reset), 32'd0);
    check("rst busy",      32'(busy),      32'd0);
    check("rst done",      32'(done),      32'd0);
    check("rst error",     32'(error),     32'd0);
    reset = 1'b1;

    // Two-word load, back-to-back
    clear_log();
    for (int i = 0; i < 11; i++) begin
      send(good[i]);
      rx_valid = (i < 10);
      if (i == 0) check("t1 busy after LEN_HI", 32'(busy), 32'd1);
      if (i == 5) check("t1 we after 4th byte", 32'(im_we), 32'd1);
      if (i == 6) check("t1 we one cycle only", 32'(im_we), 32'd0);
      if (i == 7) check("t1 ready during DATA", 32'(rx_ready), 32'd1);
      $display("t1 byte %0d = %h", i, good[i]);
    end
    rx_valid = 1'b0;
    check("t1 done",        32'(done),       32'd1);
    check("t1 cpu_reset",   32'(cpu_reset),  32'd1);
    check("t1 busy",        32'(busy),       32'd0);
    check("t1 rx_ready",    32'(rx_ready),   32'd0);
    check("t1 nwrites",     32'(wd_log.size()), 32'd2);
    check("t1 addr0",       log_addr(0),     32'd0);
    check("t1 data0",       log_data(0),     32'h2008_0005);
    check("t1 addr1",       log_addr(1),     32'd1);
    check("t1 data1",       log_data(1),     32'h0109_5020);
    check("t1 write gap",   32'(log_gap()),  32'd4);
    repeat (3) @(posedge clock); #1;
    check("t1 addr hold",   32'(im_addr),    32'd1);
    check("t1 data hold",   im_wdata,        32'h0109_5020);
    check("t1 done sticky", 32'(done),       32'd1);

    // Empty program
    pulse_reset();
    check("rst2 done",  32'(done),    32'd0);
    check("rst2 addr",  32'(im_addr), 32'd0);
    check("rst2 wdata", im_wdata,     32'd0);
    clear_log();
    send(8'h00); send(8'h00);
    check("t2 done before csum", 32'(done), 32'd0);
    send(8'h00);
    $display("t2 empty frame sent");
    check("t2 done",      32'(done),          32'd1);
    check("t2 cpu_reset", 32'(cpu_reset),     32'd1);
    check("t2 nwrites",   32'(wd_log.size()), 32'd0);

    // Bad checksum
    pulse_reset();
    clear_log();
    for (int i = 0; i < 11; i++) send(bad[i]);
    $display("t3 bad-checksum frame sent");
    check("t3 error",     32'(error),         32'd1);
    check("t3 done",      32'(done),          32'd0);
    check("t3 cpu_reset", 32'(cpu_reset),     32'd0);
    check("t3 rx_ready",  32'(rx_ready),      32'd0);
    check("t3 nwrites",   32'(wd_log.size()), 32'd2);
    check("t3 data0",     log_data(0),        32'h2008_0005);
    check("t3 data1",     log_data(1),        32'h0109_5020);
    send(8'h55);
    repeat (2) @(posedge clock); #1;
    check("t3 error sticky", 32'(error),         32'd1);
    check("t3 no more wr",   32'(wd_log.size()), 32'd2);

    // Oversize on the 16-word instance: 17 words requested
    pulse_reset();
    w4_n = 0;
    send4(8'h00); send4(8'h11);
    $display("t4 oversize length 0x0011 sent");
    check("t4 error",    32'(error4),    32'd1);
    check("t4 busy",     32'(busy4),     32'd0);
    check("t4 rx_ready", 32'(rx_ready4), 32'd0);
    for (int i = 0; i < 5; i++) send4(8'h12);
    check("t4 nwrites",  32'(w4_n),      32'd0);
    check("t4 cpu_rst",  32'(cpu_reset4), 32'd0);

    // Exactly full capacity: 16 words of bytes 0..63, XOR of which is 0
    pulse_reset();
    w4_n = 0;
    send4(8'h00); send4(8'h10);
    check("t4b error",    32'(error4),    32'd0);
    check("t4b busy",     32'(busy4),     32'd1);
    check("t4b rx_ready", 32'(rx_ready4), 32'd1);
    for (int i = 0; i < 64; i++) send4(8'(i));
    send4(8'h00);
    $display("t4b full-capacity frame sent, writes=%0d", w4_n);
    check("t4b done",      32'(done4),        32'd1);
    check("t4b nwrites",   32'(w4_n),         32'd16);
    check("t4b last addr", 32'(w4_last_addr), 32'd15);
    check("t4b last data", w4_last_data,      32'h3C3D_3E3F);

    // Two-word load with random gaps
    pulse_reset();
    clear_log();
    for (int i = 0; i < 11; i++) begin
      int gap;
      gap = $urandom_range(0, 5);
      repeat (gap) @(posedge clock);
      #1;
      send(good[i]);
      $display("t5 byte %0d = %h after gap %0d", i, good[i], gap);
    end
    check("t5 done",    32'(done),          32'd1);
    check("t5 nwrites", 32'(wd_log.size()), 32'd2);
    check("t5 addr0",   log_addr(0),        32'd0);
    check("t5 data0",   log_data(0),        32'h2008_0005);
    check("t5 addr1",   log_addr(1),        32'd1);
    check("t5 data1",   log_data(1),        32'h0109_5020);

    // Reset mid-load, then a one-word frame
    pulse_reset();
    for (int i = 0; i < 7; i++) send(good[i]);
    pulse_reset();
    check("t6 busy after abort", 32'(busy),  32'd0);
    check("t6 we after abort",   32'(im_we), 32'd0);
    check("t6 done after abort", 32'(done),  32'd0);
    clear_log();
    for (int i = 0; i < 7; i++) send(one[i]);
    $display("t6 one-word frame sent");
    check("t6 done",    32'(done),          32'd1);
    check("t6 nwrites", 32'(wd_log.size()), 32'd1);
    check("t6 addr0",   log_addr(0),        32'd0);
    check("t6 data0",   log_data(0),        32'hAABB_CCDD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
